// File: rtl/numa_bank_scheduler.sv
// Per-bank TCDM target scheduler: round-robin arbitration with starvation aging, an
// outstanding-transaction credit limit and an in-order response queue with ready back-pressure.
module numa_bank_scheduler #(
  parameter int unsigned NumIn          = 8,
  parameter int unsigned AddrMemWidth   = 12,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumOutstanding = 2,
  parameter int unsigned StarveLimit    = 15
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumIn-1:0]                    req_i,
  input  logic [NumIn*AddrMemWidth-1:0]       add_i,
  input  logic [NumIn-1:0]                    wen_i,
  input  logic [NumIn*DataWidth-1:0]          wdata_i,
  input  logic [NumIn*(DataWidth/8)-1:0]      be_i,
  output logic [NumIn-1:0]                    gnt_o,
  output logic [NumIn-1:0]                    vld_o,
  input  logic [NumIn-1:0]                    rdy_i,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                bank_req_o,
  output logic [AddrMemWidth-1:0]             bank_add_o,
  output logic                                bank_wen_o,
  output logic [DataWidth-1:0]                bank_wdata_o,
  output logic [(DataWidth/8)-1:0]            bank_be_o,
  input  logic [DataWidth-1:0]                bank_rdata_i
);
  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned IdxW    = $clog2(NumIn);
  localparam int unsigned CredW   = $clog2(NumOutstanding + 1);
  localparam int unsigned AgeW    = $clog2(StarveLimit + 1);
  localparam int unsigned PtrW    = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam logic [AgeW-1:0]  AgeMax  = AgeW'(StarveLimit);
  localparam logic [CredW-1:0] CredMax = CredW'(NumOutstanding);

  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CredW-1:0]     credits_q, credits_d;
  logic [AgeW-1:0]      age_q [NumIn];
  logic [AgeW-1:0]      age_d [NumIn];
  logic                 vld_p1_q, vld_p1_d;
  logic [IdxW-1:0]      idx_p1_q, idx_p1_d;
  logic                 wen_p1_q, wen_p1_d;
  logic [DataWidth-1:0] fdata_q [NumOutstanding];
  logic [IdxW-1:0]      fidx_q [NumOutstanding];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CredW-1:0]     cnt_q, cnt_d;

  logic [IdxW-1:0]      winner;
  logic                 any_win, grant;
  logic                 fifo_empty, head_vld, pop, push, fifo_pop;
  logic [IdxW-1:0]      head_idx;
  logic [DataWidth-1:0] head_data, push_data;

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NumIn) s = s - NumIn;
    return IdxW'(s);
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(NumOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Starving requesters (lowest index) beat the round-robin search.
  always_comb begin
    winner  = '0;
    any_win = 1'b0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      if (!any_win && req_i[i] && age_q[i] == AgeMax) begin
        winner  = IdxW'(i);
        any_win = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NumIn; k++) begin
      if (!any_win && req_i[wrap_idx(rr_ptr_q, k)]) begin
        winner  = wrap_idx(rr_ptr_q, k);
        any_win = 1'b1;
      end
    end
    grant = any_win && (credits_q != '0) && rst_ni;
  end

  always_comb begin
    gnt_o        = '0;
    bank_req_o   = grant;
    bank_add_o   = '0;
    bank_wen_o   = 1'b0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    if (grant) begin
      gnt_o[winner] = 1'b1;
      bank_add_o    = add_i[winner*AddrMemWidth +: AddrMemWidth];
      bank_wen_o    = wen_i[winner];
      bank_wdata_o  = wdata_i[winner*DataWidth +: DataWidth];
      bank_be_o     = be_i[winner*BeWidth +: BeWidth];
    end
  end

  // The access in the SRAM read stage is the logical head whenever the queue is empty.
  always_comb begin
    fifo_empty = (cnt_q == '0);
    push_data  = wen_p1_q ? '0 : bank_rdata_i;
    head_vld   = !fifo_empty || vld_p1_q;
    head_idx   = fifo_empty ? idx_p1_q : fidx_q[rd_ptr_q];
    head_data  = fifo_empty ? push_data : fdata_q[rd_ptr_q];
    pop        = head_vld && rdy_i[head_idx];
    push       = vld_p1_q && !(fifo_empty && pop);
    fifo_pop   = pop && !fifo_empty;
    vld_o      = '0;
    rdata_o    = '0;
    if (head_vld) begin
      vld_o[head_idx] = 1'b1;
      rdata_o         = head_data;
    end
  end

  always_comb begin
    rr_ptr_d = grant ? wrap_idx(winner, 1) : rr_ptr_q;
    vld_p1_d = grant;
    idx_p1_d = winner;
    wen_p1_d = bank_wen_o;
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = fifo_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !fifo_pop) cnt_d = cnt_q + CredW'(1);
    else if (!push && fifo_pop) cnt_d = cnt_q - CredW'(1);
    credits_d = credits_q;
    if (grant && !pop) credits_d = credits_q - CredW'(1);
    else if (!grant && pop) credits_d = credits_q + CredW'(1);
    for (int unsigned i = 0; i < NumIn; i++) begin
      if (gnt_o[i] || !req_i[i]) age_d[i] = '0;
      else if (age_q[i] != AgeMax) age_d[i] = age_q[i] + AgeW'(1);
      else age_d[i] = age_q[i];
    end
  end

  // Control state: grant pointer, credits, ages, read-stage valid, queue pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      credits_q <= CredMax;
      vld_p1_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < NumIn; i++) age_q[i] <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
      vld_p1_q  <= vld_p1_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      for (int unsigned i = 0; i < NumIn; i++) age_q[i] <= age_d[i];
    end
  end

  // Data path: read-stage tag and queue payload
  always_ff @(posedge clk_i) begin
    idx_p1_q <= idx_p1_d;
    wen_p1_q <= wen_p1_d;
    if (push) begin
      fdata_q[wr_ptr_q] <= push_data;
      fidx_q[wr_ptr_q]  <= idx_p1_q;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(vld_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) (gnt_o & ~req_i) == '0);
  assert property (@(posedge clk_i) disable iff (!rst_ni) credits_q <= CredMax);
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && !fifo_pop && cnt_q == CredMax));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && !grant && credits_q == CredMax));
endmodule

// File: tb/tb_numa_bank_scheduler.sv
// Bench for numa_bank_scheduler: SRAM model, queue-based reference model checked every
// cycle, and directed scenarios with literal expectations.
module tb_numa_bank_scheduler;
  localparam int N = 8, AW = 12, DW = 32, BW = 4, NO = 2, SL = 8;

  logic clk = 1'b0, rst_ni = 1'b0;
  logic [N-1:0] req_i = '0, wen_i = '0, rdy_i = '0, gnt_o, vld_o;
  logic [N*AW-1:0] add_i;
  logic [N*DW-1:0] wdata_i;
  logic [N*BW-1:0] be_i;
  logic [DW-1:0] rdata_o, bank_wdata_o, bank_rdata_i = '0;
  logic bank_req_o, bank_wen_o;
  logic [AW-1:0] bank_add_o;
  logic [BW-1:0] bank_be_o;
  int checks = 0, errors = 0;

  numa_bank_scheduler #(.NumIn(N), .AddrMemWidth(AW), .DataWidth(DW),
                        .NumOutstanding(NO), .StarveLimit(SL)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .vld_o(vld_o), .rdy_i(rdy_i),
    .rdata_o(rdata_o), .bank_req_o(bank_req_o), .bank_add_o(bank_add_o),
    .bank_wen_o(bank_wen_o), .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o),
    .bank_rdata_i(bank_rdata_i));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM bank: one-cycle read latency, byte-enabled writes
  logic [DW-1:0] mem [4096];
  always @(posedge clk) begin
    if (bank_req_o) begin
      if (bank_wen_o) mem[bank_add_o] <= merge(mem[bank_add_o], bank_wdata_o, bank_be_o);
      else bank_rdata_i <= mem[bank_add_o];
    end
  end

  // Reference model: outstanding responses kept as an ordered list
  typedef struct { int idx; logic [DW-1:0] data; } resp_t;
  resp_t m_q[$];
  int m_age[N];
  int m_rr;
  logic [DW-1:0] mmem [4096];

  always @(negedge clk) begin
    logic [N-1:0] e_vld, e_gnt;
    logic [DW-1:0] e_rd;
    int win;
    resp_t r;
    if (!rst_ni) begin
      m_q.delete();
      m_rr = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
      chk("rst_gnt", gnt_o, 0);
      chk("rst_vld", vld_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_bank_req", bank_req_o, 0);
    end else begin
      e_vld = '0; e_rd = '0; e_gnt = '0; win = -1;
      if (m_q.size() > 0) begin
        e_vld[m_q[0].idx] = 1'b1;
        e_rd = m_q[0].data;
      end
      if (m_q.size() < NO) begin
        for (int i = 0; i < N; i++) if (win < 0 && req_i[i] && m_age[i] == SL) win = i;
        for (int k = 0; k < N; k++) if (win < 0 && req_i[(m_rr + k) % N]) win = (m_rr + k) % N;
      end
      if (win >= 0) e_gnt[win] = 1'b1;
      chk("m_gnt", gnt_o, e_gnt);
      chk("m_vld", vld_o, e_vld);
      chk("m_rdata", rdata_o, e_rd);
      chk("m_bank_req", bank_req_o, win >= 0);
      if (win >= 0) begin
        chk("m_bank_add", bank_add_o, add_i[win*AW +: AW]);
        chk("m_bank_wen", bank_wen_o, wen_i[win]);
        if (wen_i[win]) begin
          chk("m_bank_wdata", bank_wdata_o, wdata_i[win*DW +: DW]);
          chk("m_bank_be", bank_be_o, be_i[win*BW +: BW]);
        end
      end
      if (m_q.size() > 0 && rdy_i[m_q[0].idx]) void'(m_q.pop_front());
      if (win >= 0) begin
        r.idx = win;
        if (wen_i[win]) begin
          r.data = '0;
          mmem[add_i[win*AW +: AW]] = merge(mmem[add_i[win*AW +: AW]], wdata_i[win*DW +: DW],
                                            be_i[win*BW +: BW]);
        end else r.data = mmem[add_i[win*AW +: AW]];
        m_q.push_back(r);
        m_rr = (win + 1) % N;
      end
      for (int i = 0; i < N; i++)
        m_age[i] = (e_gnt[i] || !req_i[i]) ? 0 : ((m_age[i] < SL) ? m_age[i] + 1 : SL);
    end
  end

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] y);
    @(posedge clk); #1;
    req_i = r; rdy_i = y;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ni = 1'b0; req_i = '0; rdy_i = '0;
    @(negedge clk); #1;
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      mem[a] = 32'hA000_0000 | a;
      mmem[a] = 32'hA000_0000 | a;
    end
    mem[16] = 32'h0000_CAFE;
    mmem[16] = 32'h0000_CAFE;
    for (int i = 0; i < N; i++) begin
      add_i[i*AW +: AW] = AW'(12'h100 + i);
      wdata_i[i*DW +: DW] = 32'h1111_1111 * (i + 1);
      be_i[i*BW +: BW] = 4'hF;
    end
    add_i[0 +: AW] = 12'h010;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    // single load
    cyc(8'h01, 8'hFF);
    chk("t1_gnt", gnt_o, 8'h01);
    chk("t1_bank_add", bank_add_o, 12'h010);
    cyc(8'h00, 8'hFF);
    chk("t1_vld", vld_o, 8'h01);
    chk("t1_rdata", rdata_o, 32'h0000_CAFE);

    // all requesting: strict rotation
    do_reset();
    for (int k = 0; k < 17; k++) begin
      logic [N-1:0] e;
      cyc(8'hFF, 8'hFF);
      e = '0; e[k % N] = 1'b1;
      chk("t2_rot_gnt", gnt_o, e);
    end

    // credit stall, starvation priority, grant+pop at credits=1
    do_reset();
    cyc(8'h01, 8'h00); chk("t3_gnt0", gnt_o, 8'h01);
    cyc(8'h02, 8'h00); chk("t3_gnt1", gnt_o, 8'h02); chk("t3_vld0", vld_o, 8'h01);
    cyc(8'h20, 8'h00); chk("t3_no_gnt", gnt_o, 8'h00); chk("t3_held", vld_o, 8'h01);
    chk("t3_held_data", rdata_o, 32'h0000_CAFE);
    repeat (6) begin
      cyc(8'h20, 8'h00); chk("t3_stall_gnt", gnt_o, 8'h00);
    end
    cyc(8'h20, 8'hFF); chk("t3_pop_gnt", gnt_o, 8'h00); chk("t3_pop_vld", vld_o, 8'h01);
    cyc(8'h24, 8'hFF); chk("t4_starve_gnt", gnt_o, 8'h20); chk("t5_vld1", vld_o, 8'h02);
    chk("t5_rdata1", rdata_o, 32'hA000_0101);
    cyc(8'h04, 8'hFF); chk("t5_gnt2", gnt_o, 8'h04); chk("t5_vld5", vld_o, 8'h20);
    chk("t5_rdata5", rdata_o, 32'hA000_0105);
    cyc(8'h00, 8'hFF); chk("t5_vld2", vld_o, 8'h04); chk("t5_idle_gnt", gnt_o, 8'h00);

    // reset with two in flight
    do_reset();
    cyc(8'hFF, 8'h00); chk("t6_gnt0", gnt_o, 8'h01);
    cyc(8'hFF, 8'h00); chk("t6_gnt1", gnt_o, 8'h02);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(negedge clk); #1;
    chk("t6_rst_vld", vld_o, 8'h00);
    chk("t6_rst_gnt", gnt_o, 8'h00);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk); #1;
    chk("t6_post_gnt", gnt_o, 8'h01);
    chk("t6_no_stale", vld_o, 8'h00);
    cyc(8'hFF, 8'hFF); chk("t6_two_credits", gnt_o, 8'h02); chk("t6_vld", vld_o, 8'h01);
    cyc(8'h00, 8'hFF);
    cyc(8'h00, 8'hFF);

    // store then load of the same word
    wen_i[3] = 1'b1;
    wdata_i[3*DW +: DW] = 32'h1234_5678;
    be_i[3*BW +: BW] = 4'b0101;
    add_i[3*AW +: AW] = 12'h020;
    add_i[4*AW +: AW] = 12'h020;
    cyc(8'h08, 8'hFF); chk("st_gnt", gnt_o, 8'h08); chk("st_bank_wen", bank_wen_o, 1'b1);
    cyc(8'h10, 8'hFF); chk("ld_gnt", gnt_o, 8'h10); chk("st_vld", vld_o, 8'h08);
    chk("st_rdata", rdata_o, 32'h0);
    cyc(8'h00, 8'hFF); chk("ld_vld", vld_o, 8'h10); chk("ld_rdata", rdata_o, 32'hA034_0078);
    wen_i[3] = 1'b0;
    cyc(8'h00, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
